// File: rtl/bin_to_bcd_display_pkg.sv
// bin_to_bcd_display_pkg: shared FSM states and BCD digit geometry
package bin_to_bcd_display_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int NUM_DIGITS = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/bin_to_bcd_display_if.sv
// bin_to_bcd_display_if: request/result bundle between a client and the converter
interface bin_to_bcd_display_if #(parameter int BIN_WIDTH = 14);
  import bin_to_bcd_display_pkg::*;
  logic [BIN_WIDTH-1:0] bin_in;
  logic start;
  logic busy;
  logic done;
  logic overflow;
  logic [BCD_DIGIT_W-1:0] displayA;
  logic [BCD_DIGIT_W-1:0] displayB;
  logic [BCD_DIGIT_W-1:0] displayC;
  logic [BCD_DIGIT_W-1:0] displayD;
  modport master (output bin_in, start, input busy, done, overflow, displayA, displayB, displayC, displayD);
  modport slave (input bin_in, start, output busy, done, overflow, displayA, displayB, displayC, displayD);
endinterface

// File: rtl/bin_to_bcd_display_bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to any digit of 5 or more
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);
  assign adjusted = digit >= 4'd5 ? digit + 4'd3 : digit;
endmodule

// File: rtl/bin_to_bcd_display.sv
// bin_to_bcd_display: sequential shift-add-3 binary to 4-digit BCD converter with saturation
module bin_to_bcd_display
  import bin_to_bcd_display_pkg::*;
#(
  parameter int BIN_WIDTH = 14,
  parameter int MAX_VALUE = 9999
) (
  input logic clk_25MHz,
  input logic reset_n,
  bin_to_bcd_display_if.slave bcd
);
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int SW = BCD_DIGIT_W * NUM_DIGITS;
  localparam logic [BIN_WIDTH-1:0] MAX_BIN = BIN_WIDTH'(MAX_VALUE);
  state_t state, state_nxt;
  logic [BIN_WIDTH-1:0] shift;
  logic [SW-1:0] scratch, adj, digits;
  logic [CW-1:0] cnt;
  logic ovf, busy, done, overflow;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (.digit(scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W]), .adjusted(adj[i*BCD_DIGIT_W +: BCD_DIGIT_W]));
  end
  always_comb begin
    state_nxt = IDLE;
    state_nxt = state == IDLE  ? (bcd.start ? SHIFT : IDLE) :
                state == SHIFT ? (cnt == CW'(BIN_WIDTH - 1) ? DONE : SHIFT) : IDLE;
  end
  // display registers only move on the DONE edge so partial results never show
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      shift <= '0;
      scratch <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
      digits <= '0;
    end else begin
      state <= state_nxt;
      done <= 1'b0;
      if (state == IDLE && bcd.start) begin
        shift <= bcd.bin_in > MAX_BIN ? MAX_BIN : bcd.bin_in;
        ovf <= bcd.bin_in > MAX_BIN;
        scratch <= '0;
        cnt <= '0;
        busy <= 1'b1;
      end
      if (state == SHIFT) begin
        scratch <= {adj[SW-2:0], shift[BIN_WIDTH-1]};
        shift <= {shift[BIN_WIDTH-2:0], 1'b0};
        cnt <= cnt + 1'b1;
      end
      if (state == DONE) begin
        digits <= scratch;
        overflow <= ovf;
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
  assign bcd.busy = busy;
  assign bcd.done = done;
  assign bcd.overflow = overflow;
  assign {bcd.displayA, bcd.displayB, bcd.displayC, bcd.displayD} = digits;
endmodule
